// File: rtl/config_loader_pkg.sv
// config_loader_pkg: shared FSM state type and sizing helpers for the configuration loader.
package config_loader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, RUN, ERROR} state_t;

    // Number of bitstream data words needed to cover cw configuration bits.
    function automatic int n_words(input int cw, input int ww);
        return (cw + ww - 1) / ww;
    endfunction

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/config_loader.sv
// config_loader: word-serial bitstream loader with XOR trailer check, atomic commit and fabric reset sequencing.
//   clock, nreset           : clock and synchronous active-low reset
//   start                   : one-cycle (re)load request, honoured in IDLE, RUN and ERROR
//   word_in/valid/ready     : bitstream handshake (N_WORDS data words, then one trailer word)
//   config_out              : committed configuration image to the tile
//   fabric_nreset/enable    : fabric register reset and enable, released only in RUN
//   config_done             : a verified configuration is running
//   error                   : the last load failed its checksum
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = 20,
    parameter int WORD_WIDTH   = 8,
    parameter int RESET_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    fabric_nreset,
    output logic                    fabric_enable,
    output logic                    config_done,
    output logic                    error
);

    localparam int N_WORDS = n_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int WC_W    = cnt_width(N_WORDS);
    localparam int RC_W    = cnt_width(RESET_CYCLES);

    state_t                  state, next;
    logic [WC_W-1:0]         word_cnt;
    logic [RC_W-1:0]         rel_cnt;
    logic [WORD_WIDTH-1:0]   sum;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    xfer;
    int                      sh;

    assign xfer = word_valid && word_ready;
    assign sh   = int'(word_cnt) * WORD_WIDTH;

    always_ff @(posedge clock)
        state <= !nreset ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE, RUN, ERROR: next = start ? LOAD : state;
            LOAD:    next = (xfer && word_cnt == WC_W'(N_WORDS - 1)) ? CHECK : LOAD;
            CHECK:   next = xfer ? (word_in == sum ? RELEASE : ERROR) : CHECK;
            RELEASE: next = (rel_cnt == RC_W'(RESET_CYCLES - 1)) ? RUN : RELEASE;
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            word_ready    <= 1'b0;
            fabric_nreset <= 1'b0;
            fabric_enable <= 1'b0;
            config_done   <= 1'b0;
            error         <= 1'b0;
            config_out    <= '0;
            shadow        <= '0;
            sum           <= '0;
            word_cnt      <= '0;
            rel_cnt       <= '0;
        end else begin
            word_ready    <= next == LOAD || next == CHECK;
            fabric_nreset <= next == RUN;
            fabric_enable <= next == RUN;
            config_done   <= next == RUN;
            rel_cnt       <= state == RELEASE ? rel_cnt + 1'b1 : '0;
            if ((state == IDLE || state == RUN || state == ERROR) && start) begin
                word_cnt <= '0;
                sum      <= '0;
            end
            if (state == LOAD && xfer) begin
                // Bits of the last word beyond CONFIG_WIDTH fall off the top of the shift.
                shadow   <= (shadow & ~(CONFIG_WIDTH'({WORD_WIDTH{1'b1}}) << sh))
                          | (CONFIG_WIDTH'(word_in) << sh);
                sum      <= sum ^ word_in;
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == CHECK && xfer) begin
                if (word_in == sum) begin
                    config_out <= shadow;
                    error      <= 1'b0;
                end else begin
                    error      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration loader feeding the `config_in` buses of a tile's logic elements and routing. It accepts a word-serial bitstream over a valid/ready handshake and assembles it in a shadow register. It verifies a trailer checksum, then commits the image atomically to `config_out`. It sequences the fabric reset and enable so logic elements never run on a partial or corrupt configuration.

## Interface
- `CONFIG_WIDTH`, 20: total configuration bits driven to the tile.
- `WORD_WIDTH`, 8: bitstream word width.
- `RESET_CYCLES`, 2: cycles `fabric_nreset` stays low after commit; ≥1.
- `clock`  in  1  clock.
- `nreset`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse requesting a (re)load.
- `word_in`  in  `WORD_WIDTH`  bitstream word.
- `word_valid`  in  1  `word_in` valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `config_out`  out  `CONFIG_WIDTH`  committed configuration to the fabric.
- `fabric_nreset`  out  1  synchronous active-low reset to fabric registers.
- `fabric_enable`  out  1  enable to fabric registers.
- `config_done`  out  1  valid configuration is running.
- `error`  out  1  last load failed its checksum.

## Operation
- N_WORDS = ceil(`CONFIG_WIDTH`/`WORD_WIDTH`). Each load is N_WORDS data words followed by 1 trailer word.
- Data word k (0-based) goes to shadow bits [k·W +: W]. Shadow bits at or above `CONFIG_WIDTH` are discarded.
- The running checksum is the XOR of all data words. The trailer must equal it.
- A word transfers when `word_valid` and `word_ready` are both high.
- States:
  - IDLE: `word_ready`=0. On `start`, go to LOAD and clear the word counter and checksum.
  - LOAD: `word_ready`=1. Each transfer writes the shadow and updates the checksum. After the N_WORDS-th transfer, go to CHECK.
  - CHECK: `word_ready`=1. On transfer, compare the trailer to the checksum.
    - Match: copy shadow to `config_out`, clear `error`, go to RELEASE.
    - Mismatch: leave `config_out` unchanged, set `error`, go to ERROR.
  - RELEASE: count `RESET_CYCLES` cycles, then go to RUN.
  - RUN: `fabric_nreset`=1, `fabric_enable`=1, `config_done`=1. On `start`, go to LOAD.
  - ERROR: `word_ready`=0. On `start`, go to LOAD; `error` clears only on a successful commit.
- `fabric_nreset`=0 and `fabric_enable`=0 in every state except RUN.
- `config_done`=1 only in RUN.
- `start` is ignored in LOAD, CHECK and RELEASE.
- `config_out` changes only on a successful commit. A reload keeps the old image until the new one commits.
- Extra words offered after the trailer are not accepted.

## Timing
- Reset (`nreset`=0 at a clock edge): state IDLE, `config_out`=0, `word_ready`=0, `fabric_nreset`=0, `fabric_enable`=0, `config_done`=0, `error`=0, counters and checksum cleared.
- Reset applies in any state, including mid-load; the partial shadow is discarded.
- `start` at edge t: `word_ready`=1 from cycle t+1.
- Back-to-back transfers run at one word per cycle. `word_valid` gaps stall the load indefinitely; there is no timeout.
- Trailer accepted at edge t:
  - `config_out` is valid and state is RELEASE from t+1.
  - `fabric_nreset`, `fabric_enable` and `config_done` rise at t+1+`RESET_CYCLES`.
- Mismatched trailer at edge t: `error`=1 from t+1.
- `start` in RUN at edge t: `fabric_enable`, `fabric_nreset` and `config_done` drop at t+1, and `word_ready` rises at t+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `config_loader_pkg`: state enum (IDLE, LOAD, CHECK, RELEASE, RUN, ERROR), and a function computing N_WORDS and the counter widths ($clog2(N_WORDS+1), $clog2(RESET_CYCLES+1)).
- Single module; no sub-module. The shadow register and the committed register are separate flops.

## Test plan
Defaults: N_WORDS=3.
- Nominal load: start, words 0xA5, 0x3C, 0x0F, trailer 0x96 → `config_out`=0xF3CA5; fabric signals and `config_done` rise 2 cycles after the trailer; `error`=0.
- Bad checksum: same data, trailer 0x97 → `error`=1, `config_out`=0, state ERROR, `word_ready`=0; a following good load clears `error`.
- Stalled handshake: `word_valid` toggles 1-0-0-1 between words → identical result to the nominal load; nothing is accepted while `word_valid`=0.
- Reload from RUN: running 0xF3CA5, start, load 0x11, 0x22, 0x03 with trailer 0x30:
  - during the load, `config_out` stays 0xF3CA5 and `fabric_enable`=0;
  - after commit, `config_out`=0x32211.
- Mid-load reset: `nreset`=0 after the 2nd word → all outputs at reset values; the next full load succeeds normally.
- Start ignored: pulse `start` during LOAD and during RELEASE → no restart; word count and commit timing unchanged.
